t01_ai_mmu_sequencer: RTL and testbench

Controller for the t01 AI systolic matrix-multiply unit (N×N MAC array). It runs one N×N tile product per start command:
- clears the array accumulators;
- fetches A columns and B rows from the tile buffers;
- applies the diagonal skew on the west and north edges and zero-fills outside the wavefront;
- waits out the array drain, then holds `done` until the consumer acknowledges.

It sits between the layer scheduler (start/ack) and the array and tile buffers.

---
 rtl/t01_ai_mmu_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_t01_ai_mmu_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t01_ai_mmu_sequencer.sv
// Tile sequencer for the t01 systolic MAC array: clear, feed with diagonal skew,
// drain, then hold done until the consumer acknowledges.

module t01_ai_mmu_skew_lane #(
   parameter int DEPTH = 0,
   parameter int DW    = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   input  logic          vld_i,
   input  logic [DW-1:0] data_i,
   output logic [DW-1:0] data_o
);
   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_ctl;
         assign unused_ctl = ^{clk_i, rst_i, flush_i};
         assign data_o     = vld_i ? data_i : '0;
      end else begin : g_pipe
         logic [DEPTH-1:0]         vld_q;
         logic [DEPTH-1:0][DW-1:0] dat_q;

         always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
               vld_q <= '0;
            end else begin
               vld_q[0] <= vld_i;
               for (int s = 1; s < DEPTH; s++) vld_q[s] <= vld_q[s-1];
            end
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               dat_q <= '0;
            end else begin
               dat_q[0] <= data_i;
               for (int s = 1; s < DEPTH; s++) dat_q[s] <= dat_q[s-1];
            end
         end

         // Zero-fill outside the wavefront so stale data never reaches a PE.
         assign data_o = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : '0;
      end
   endgenerate
endmodule

module t01_ai_mmu_sequencer #(
   parameter int N  = 16,
   parameter int DW = 32,
   parameter int AW = $clog2(N)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic                 done_ack_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [15:0]          tile_count_o,
   output logic                 rd_en_o,
   output logic [AW-1:0]        rd_addr_o,
   input  logic [N-1:0][DW-1:0] a_rd_data_i,
   input  logic [N-1:0][DW-1:0] b_rd_data_i,
   output logic                 mmu_clr_o,
   output logic [N-1:0][DW-1:0] inp_west_o,
   output logic [N-1:0][DW-1:0] inp_north_o
);
   localparam int CW = $clog2(2*N - 1);
   localparam logic [CW-1:0] K_LAST = CW'(N - 1);
   localparam logic [CW-1:0] D_LAST = CW'(2*N - 2);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   tile_q, tile_d;
   logic          clr_q, clr_d;
   logic          rd_vld_q, rd_vld_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         tile_q   <= '0;
         clr_q    <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tile_q   <= tile_d;
         clr_q    <= clr_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   // One counter serves as the FEED k index and the DRAIN cycle count.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tile_d   = tile_q;
      clr_d    = 1'b0;
      rd_vld_d = 1'b0;
      busy_o   = 1'b0;
      done_o   = 1'b0;
      rd_en_o  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_CLEAR;
               clr_d   = 1'b1;
            end
         end
         S_CLEAR: begin
            busy_o  = 1'b1;
            state_d = S_FEED;
            cnt_d   = '0;
         end
         S_FEED: begin
            busy_o   = 1'b1;
            rd_en_o  = 1'b1;
            rd_vld_d = 1'b1;
            if (cnt_q == K_LAST) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            busy_o = 1'b1;
            if (cnt_q == D_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            done_o = 1'b1;
            if (done_ack_i) begin
               state_d = S_IDLE;
               tile_d  = tile_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort_i) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         tile_d   = tile_q;
         clr_d    = 1'b1;
         rd_vld_d = 1'b0;
      end
   end

   assign rd_addr_o    = rd_en_o ? cnt_q[AW-1:0] : '0;
   assign mmu_clr_o    = clr_q;
   assign tile_count_o = tile_q;

   // Lane i carries i register stages so element k meets PE(i,j) on the diagonal.
   for (genvar i = 0; i < N; i++) begin : g_lane
      t01_ai_mmu_skew_lane #(.DEPTH(i), .DW(DW)) u_west (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .flush_i (abort_i),
         .vld_i   (rd_vld_q),
         .data_i  (a_rd_data_i[i]),
         .data_o  (inp_west_o[i])
      );
      t01_ai_mmu_skew_lane #(.DEPTH(i), .DW(DW)) u_north (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .flush_i (abort_i),
         .vld_i   (rd_vld_q),
         .data_i  (b_rd_data_i[i]),
         .data_o  (inp_north_o[i])
      );
   end
endmodule

// File: tb/tb_t01_ai_mmu_sequencer.sv
// Directed bench for t01_ai_mmu_sequencer at N=4 with a tile-buffer model and
// a small systolic array model driven by the sequencer's edge feeds.

module tb_t01_ai_mmu_sequencer;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = $clog2(N);

   logic                 clk = 1'b0;
   logic                 rst, start, abort, done_ack;
   logic                 busy, done, rd_en, mmu_clr;
   logic [15:0]          tile_count;
   logic [AW-1:0]        rd_addr;
   logic [N-1:0][DW-1:0] a_rd_data, b_rd_data, inp_west, inp_north;

   int checks = 0;
   int errors = 0;
   int exp_tiles = 0;

   logic [DW-1:0] a_mem [N][N];
   logic [DW-1:0] b_mem [N][N];
   logic [DW-1:0] a_pass [N][N];
   logic [DW-1:0] b_pass [N][N];
   logic [DW-1:0] a_in [N][N];
   logic [DW-1:0] b_in [N][N];
   logic [DW-1:0] acc [N][N];

   always #5 clk = ~clk;

   t01_ai_mmu_sequencer #(.N(N), .DW(DW), .AW(AW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .abort_i      (abort),
      .done_ack_i   (done_ack),
      .busy_o       (busy),
      .done_o       (done),
      .tile_count_o (tile_count),
      .rd_en_o      (rd_en),
      .rd_addr_o    (rd_addr),
      .a_rd_data_i  (a_rd_data),
      .b_rd_data_i  (b_rd_data),
      .mmu_clr_o    (mmu_clr),
      .inp_west_o   (inp_west),
      .inp_north_o  (inp_north)
   );

   // Tile buffers: one-cycle read latency, junk on the bus when not reading.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rd_en) begin
            a_rd_data[i] <= a_mem[i][rd_addr];
            b_rd_data[i] <= b_mem[rd_addr][i];
         end else begin
            a_rd_data[i] <= 32'hDEAD_0000 + 32'(i);
            b_rd_data[i] <= 32'hBEEF_0000 + 32'(i);
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_r
      for (genvar gj = 0; gj < N; gj++) begin : g_c
         if (gj == 0) begin : g_w0
            assign a_in[gi][gj] = inp_west[gi];
         end else begin : g_wn
            assign a_in[gi][gj] = a_pass[gi][gj-1];
         end
         if (gi == 0) begin : g_n0
            assign b_in[gi][gj] = inp_north[gj];
         end else begin : g_nn
            assign b_in[gi][gj] = b_pass[gi-1][gj];
         end
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (mmu_clr) begin
               a_pass[i][j] <= '0;
               b_pass[i][j] <= '0;
               acc[i][j]    <= '0;
            end else begin
               a_pass[i][j] <= a_in[i][j];
               b_pass[i][j] <= b_in[i][j];
               acc[i][j]    <= acc[i][j] + a_in[i][j] * b_in[i][j];
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_mode(input int m);
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < N; k++) begin
            if (m == 0) begin
               a_mem[i][k] = 32'(16*i + k);
               b_mem[i][k] = 32'(16*i + k);
            end else begin
               a_mem[i][k] = (i == k) ? 32'd1 : 32'd0;
               b_mem[i][k] = 32'(i + k);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (tile_count !== 16'd0) begin errors++; $display("FAIL reset_tiles: got %h want 0", tile_count); end
      checks++; if (rd_en !== 1'b0 || rd_addr !== '0) begin errors++; $display("FAIL reset_rd: got %b/%h want 0/0", rd_en, rd_addr); end
      checks++; if (mmu_clr !== 1'b0) begin errors++; $display("FAIL reset_clr: got %b want 0", mmu_clr); end
      checks++; if (inp_west !== '0 || inp_north !== '0) begin errors++; $display("FAIL reset_feeds: got %h/%h want 0", inp_west, inp_north); end
      rst = 1'b0;
      step();
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy %b done %b want 0/0", busy, done); end
      exp_tiles = 0;
   endtask

   task automatic test_product();
      load_mode(1);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3*N) step();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL product_done: got %b want 1", done); end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            checks++;
            if (acc[i][j] !== 32'(i + j)) begin
               errors++; $display("FAIL product_c%0d%0d: got %h want %h", i, j, acc[i][j], 32'(i + j));
            end
         end
      end
      checks++; if (tile_count !== 16'd0) begin errors++; $display("FAIL product_tiles_pre: got %h want 0", tile_count); end
      done_ack = 1'b1;
      step();
      done_ack = 1'b0;
      exp_tiles++;
      checks++; if (tile_count !== 16'd1) begin errors++; $display("FAIL product_tiles_post: got %h want 1", tile_count); end
   endtask

   task automatic test_schedule();
      logic          exp_rd;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_w2, exp_n1;
      load_mode(0);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 3*N+1; c++) begin
         exp_rd   = (c >= 2 && c <= N+1);
         exp_addr = exp_rd ? AW'(c - 2) : '0;
         exp_w2   = (c >= 5 && c <= 8) ? 32'h20 + 32'(c - 5) : '0;
         exp_n1   = (c >= 4 && c <= 7) ? 32'h01 + 32'(16*(c - 4)) : '0;
         checks++; if (rd_en !== exp_rd) begin errors++; $display("FAIL sched_rd_en c%0d: got %b want %b", c, rd_en, exp_rd); end
         checks++; if (rd_addr !== exp_addr) begin errors++; $display("FAIL sched_addr c%0d: got %h want %h", c, rd_addr, exp_addr); end
         checks++; if (inp_west[2] !== exp_w2) begin errors++; $display("FAIL sched_west2 c%0d: got %h want %h", c, inp_west[2], exp_w2); end
         checks++; if (inp_north[1] !== exp_n1) begin errors++; $display("FAIL sched_north1 c%0d: got %h want %h", c, inp_north[1], exp_n1); end
         checks++; if (done !== (c == 3*N+1)) begin errors++; $display("FAIL sched_done c%0d: got %b", c, done); end
         checks++; if (busy !== (c <= 3*N)) begin errors++; $display("FAIL sched_busy c%0d: got %b", c, busy); end
         checks++; if (mmu_clr !== (c == 1)) begin errors++; $display("FAIL sched_clr c%0d: got %b", c, mmu_clr); end
         if (c < 3*N+1) step();
      end
      done_ack = 1'b1;
      step();
      done_ack = 1'b0;
      exp_tiles++;
      checks++; if (tile_count !== 16'(exp_tiles)) begin errors++; $display("FAIL sched_tiles: got %h want %h", tile_count, 16'(exp_tiles)); end
   endtask

   task automatic test_handshake();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         start = (c == 3 || c == 14);
         checks++; if (done !== (c >= 13)) begin errors++; $display("FAIL hs_done c%0d: got %b", c, done); end
         checks++; if (busy !== (c <= 12)) begin errors++; $display("FAIL hs_busy c%0d: got %b", c, busy); end
         checks++; if (mmu_clr !== (c == 1)) begin errors++; $display("FAIL hs_clr c%0d: got %b", c, mmu_clr); end
         if (c < 22) step();
      end
      done_ack = 1'b1;
      start    = 1'b1;
      step();
      done_ack = 1'b0;
      start    = 1'b0;
      exp_tiles++;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hs_idle: got done %b busy %b want 0/0", done, busy); end
      checks++; if (tile_count !== 16'(exp_tiles)) begin errors++; $display("FAIL hs_tiles: got %h want %h", tile_count, 16'(exp_tiles)); end
      step();
      checks++; if (busy !== 1'b0 || mmu_clr !== 1'b0) begin errors++; $display("FAIL hs_no_launch: got busy %b clr %b want 0/0", busy, mmu_clr); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_still_idle: got %b want 0", busy); end
   endtask

   task automatic test_abort();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      checks++; if (rd_addr !== AW'(2)) begin errors++; $display("FAIL abort_k2: got %h want 2", rd_addr); end
      checks++; if (inp_west[0] !== 32'h01 || inp_north[1] !== 32'h01) begin errors++; $display("FAIL abort_pre_feeds: got %h/%h want 1/1", inp_west[0], inp_north[1]); end
      abort = 1'b1;
      step();
      abort = 1'b0;
      for (int c = 5; c <= 5 + 3*N; c++) begin
         checks++; if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle c%0d: got busy %b rd %b done %b", c, busy, rd_en, done); end
         checks++; if (mmu_clr !== (c == 5)) begin errors++; $display("FAIL abort_clr c%0d: got %b", c, mmu_clr); end
         checks++; if (inp_west !== '0 || inp_north !== '0) begin errors++; $display("FAIL abort_feeds c%0d: got %h/%h want 0", c, inp_west, inp_north); end
         step();
      end
      checks++; if (tile_count !== 16'(exp_tiles)) begin errors++; $display("FAIL abort_tiles: got %h want %h", tile_count, 16'(exp_tiles)); end
   endtask

   task automatic test_reset_drain();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (N+3) step();
      checks++; if (busy !== 1'b1 || rd_en !== 1'b0) begin errors++; $display("FAIL rstd_in_drain: got busy %b rd %b want 1/0", busy, rd_en); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_tiles = 0;
      checks++; if (tile_count !== 16'd0 || mmu_clr !== 1'b0) begin errors++; $display("FAIL rstd_regs: got tiles %h clr %b want 0/0", tile_count, mmu_clr); end
      for (int c = 0; c < 3*N; c++) begin
         checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstd_idle c%0d: got busy %b done %b", c, busy, done); end
         checks++; if (inp_west !== '0 || inp_north !== '0) begin errors++; $display("FAIL rstd_feeds c%0d: got %h/%h want 0", c, inp_west, inp_north); end
         step();
      end
   endtask

   task automatic test_back_to_back();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int t = 0; t < 3; t++) begin
         checks++; if (mmu_clr !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_clear t%0d: got clr %b busy %b want 1/1", t, mmu_clr, busy); end
         for (int c = 2; c <= 12; c++) begin
            step();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_early t%0d c%0d: got %b want 0", t, c, done); end
         end
         step();
         checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done t%0d: got %b want 1", t, done); end
         done_ack = 1'b1;
         step();
         done_ack = 1'b0;
         exp_tiles++;
         checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle t%0d: got busy %b done %b", t, busy, done); end
         checks++; if (tile_count !== 16'(exp_tiles)) begin errors++; $display("FAIL b2b_tiles t%0d: got %h want %h", t, tile_count, 16'(exp_tiles)); end
         if (t < 2) begin
            start = 1'b1;
            step();
            start = 1'b0;
         end
      end
      checks++; if (tile_count !== 16'd3) begin errors++; $display("FAIL b2b_final: got %h want 3", tile_count); end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      done_ack = 1'b0;
      load_mode(0);
      test_reset();
      test_product();
      load_mode(0);
      test_schedule();
      test_handshake();
      test_abort();
      test_reset_drain();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
